iter_shifter: RTL

Multi-cycle shift unit for the Simple RISC Machine datapath. Applies a 1-bit shift step repeatedly so one operation can shift a 16-bit operand by 0–15 places. Uses the same shift-op encoding as the datapath's single-step shifter. A start/done handshake lets the controller FSM wait on it when an instruction needs a shift amount greater than 1.

---
 rtl/iter_shifter_pkg.sv | 19 +
 rtl/iter_shifter_shift_step.sv | 27 ++
 rtl/iter_shifter.sv | 87 ++++++++
 3 files changed

// File: rtl/iter_shifter_pkg.sv
// Shared definitions for the iterative shifter.
// Holds the 2-bit shift-op encoding (also used by the datapath single-step
// shifter and the decoder) and the iterative shifter's state encoding.
package iter_shifter_pkg;

  // Shift-op encoding
  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_LSL  = 2'b01;
  localparam logic [1:0] SH_LSR  = 2'b10;
  localparam logic [1:0] SH_ASR  = 2'b11;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step: combinational one-bit shift step, bit-identical to the
// datapath single-step shifter.
// Ports:
//   op     in  2      shift-op (SH_NONE/SH_LSL/SH_LSR/SH_ASR)
//   value  in  WIDTH  operand
//   result out WIDTH  operand after one step
module shift_step
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = value;
    case (op)
      SH_LSL:  result = {value[WIDTH-2:0], 1'b0};
      SH_LSR:  result = {1'b0, value[WIDTH-1:1]};
      SH_ASR:  result = {value[WIDTH-1], value[WIDTH-1:1]};
      default: result = value;
    endcase
  end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter that applies one shift_step per cycle
// to shift a WIDTH-bit operand by 0 .. 2^AMT_W-1 places.
// Ports:
//   clk    in  1      clock, rising edge
//   reset  in  1      synchronous active-high reset
//   start  in  1      request; accepted in IDLE or DONE only
//   in     in  WIDTH  operand, captured on accepted start
//   shift  in  2      shift-op, captured on accepted start
//   amt    in  AMT_W  step count, captured on accepted start
//   busy   out 1      high while shifting
//   done   out 1      one-cycle pulse, sout is final
//   sout   out WIDTH  result register
module iter_shifter
  import iter_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sout
);

  state_t             state;
  logic [1:0]         op;
  logic [AMT_W-1:0]   cnt;
  logic [WIDTH-1:0]   stepped;

  // Single step engine feeding the result register
  shift_step #(.WIDTH(WIDTH)) u_step (
    .op     (op),
    .value  (sout),
    .result (stepped)
  );

  // FSM, counter and result/op registers; busy/done mirror the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      sout  <= '0;
      op    <= SH_NONE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      busy <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            sout <= in;
            op   <= shift;
            cnt  <= amt;
            // Nothing to step: finish straight away
            if (amt == '0 || shift == SH_NONE) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          sout <= stepped;
          cnt  <= cnt - AMT_W'(1);
          if (cnt == AMT_W'(1)) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end else begin
            busy  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
